// File: rtl/dff_pipe_elastic.sv
// DEPTH-stage, WIDTH-bit elastic register pipeline with per-stage valid bits,
// bubble-collapsing valid/ready flow control, synchronous flush and occupancy count.
module dff_pipe_elastic #(
    parameter int unsigned      WIDTH     = 8,
    parameter int unsigned      DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [WIDTH-1:0]             din,
    input  logic                         din_valid,
    output logic                         din_ready,
    input  logic                         flush,
    output logic [WIDTH-1:0]             q,
    output logic                         q_valid,
    input  logic                         q_ready,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

    localparam int unsigned OCC_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] data_q [DEPTH];
    logic [WIDTH-1:0] data_d [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] valid_d;
    logic [OCC_W-1:0] occ_q;
    logic [OCC_W-1:0] occ_d;
    logic [DEPTH-1:0] rdy;
    logic             in_xfer;
    logic             out_xfer;

    // A stage can load when it is empty or everything downstream of it can move.
    always_comb begin : ready_chain
        logic run;
        run = q_ready;
        rdy = '0;
        for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
            run    = ~valid_q[k] | run;
            rdy[k] = run;
        end
    end

    assign din_ready = rdy[0] & ~flush & ~rst;
    assign in_xfer   = din_valid & din_ready;
    assign out_xfer  = valid_q[DEPTH-1] & q_ready;

    always_comb begin : next_state
        valid_d = valid_q;
        data_d  = data_q;
        occ_d   = occ_q;
        if (flush) begin
            valid_d = '0;
            for (int k = 0; k < int'(DEPTH); k++) begin
                data_d[k] = RESET_VAL;
            end
            occ_d = '0;
        end else begin
            if (rdy[0]) begin
                valid_d[0] = din_valid;
                if (din_valid) begin
                    data_d[0] = din;
                end
            end
            // Data only moves with a valid beat, so X on an idle bus never lands in a stage.
            for (int k = 1; k < int'(DEPTH); k++) begin
                if (rdy[k]) begin
                    valid_d[k] = valid_q[k-1];
                    if (valid_q[k-1]) begin
                        data_d[k] = data_q[k-1];
                    end
                end
            end
            occ_d = occ_q + OCC_W'(in_xfer) - OCC_W'(out_xfer);
        end
    end

    always_ff @(posedge clk or posedge rst) begin : state_reg
        if (rst) begin
            valid_q <= '0;
            occ_q   <= '0;
            for (int k = 0; k < int'(DEPTH); k++) begin
                data_q[k] <= RESET_VAL;
            end
        end else begin
            valid_q <= valid_d;
            occ_q   <= occ_d;
            for (int k = 0; k < int'(DEPTH); k++) begin
                data_q[k] <= data_d[k];
            end
        end
    end

    assign q         = data_q[DEPTH-1];
    assign q_valid   = valid_q[DEPTH-1];
    assign occupancy = occ_q;

endmodule

// File: tb/tb_dff_pipe_elastic.sv
// Bench for dff_pipe_elastic: directed scenarios plus random traffic checked by a
// FIFO-model scoreboard, and a WIDTH=1/DEPTH=1 instance exercised as a D flip-flop.
module tb_dff_pipe_elastic;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned OCC_W = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic             flush;
    logic [WIDTH-1:0] q;
    logic             q_valid;
    logic             q_ready;
    logic [OCC_W-1:0] occupancy;

    logic       din_b;
    logic       din_valid_b;
    logic       din_ready_b;
    logic       flush_b;
    logic       q_b;
    logic       q_valid_b;
    logic       q_ready_b;
    logic [0:0] occ_b;

    always #5 clk = ~clk;

    dff_pipe_elastic #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_VAL(8'h00)) dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
        .flush(flush), .q(q), .q_valid(q_valid), .q_ready(q_ready), .occupancy(occupancy)
    );

    dff_pipe_elastic #(.WIDTH(1), .DEPTH(1), .RESET_VAL(1'b0)) dut_b (
        .clk(clk), .rst(rst), .din(din_b), .din_valid(din_valid_b), .din_ready(din_ready_b),
        .flush(flush_b), .q(q_b), .q_valid(q_valid_b), .q_ready(q_ready_b), .occupancy(occ_b)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Reference model: the pipeline contents are just an ordered FIFO of accepted beats.
    logic [WIDTH-1:0] model_q [$];
    bit               mon_en = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            model_q.delete();
        end else if (mon_en) begin
            chk("mon_occupancy", 32'(occupancy), 32'(model_q.size()));
            chk("mon_din_ready", 32'(din_ready),
                32'(!flush && (model_q.size() < int'(DEPTH) || q_ready)));
            if (q_valid) begin
                if (model_q.size() == 0) chk("mon_valid_when_empty", 32'(q_valid), 32'(0));
                else                     chk("mon_q_data", 32'(q), 32'(model_q[0]));
                if (q_ready && model_q.size() > 0) void'(model_q.pop_front());
            end
            if (flush) model_q.delete();
            else if (din_valid && din_ready) model_q.push_back(din);
        end
    end

    bit               s_in;
    bit               s_out;
    logic [WIDTH-1:0] s_q;
    logic [WIDTH-1:0] s_din;

    // Sample this cycle's handshakes, then advance to just after the next rising edge.
    task automatic step();
        #2;
        s_in  = din_valid && din_ready;
        s_out = q_valid && q_ready;
        s_q   = q;
        s_din = din;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("%0d/%0d checks passed", n_pass, n_checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int               idx;
        logic [WIDTH-1:0] sent [$];
        logic [WIDTH-1:0] got  [$];
        logic             exp_qb;
        logic             exp_vb;

        rst = 1'b1; din = '0; din_valid = 1'b0; flush = 1'b0; q_ready = 1'b0;
        din_b = 1'b0; din_valid_b = 1'b0; flush_b = 1'b0; q_ready_b = 1'b1;
        #2;
        chk("rst_q_valid", 32'(q_valid), 32'(0));
        chk("rst_occupancy", 32'(occupancy), 32'(0));
        chk("rst_q", 32'(q), 32'(0));
        chk("rst_din_ready", 32'(din_ready), 32'(0));
        chk("rst_b_q_valid", 32'(q_valid_b), 32'(0));
        @(posedge clk);
        @(posedge clk);
        #1;
        rst    = 1'b0;
        mon_en = 1'b1;

        // 1: streaming with no back-pressure
        q_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            din_valid = 1'b1;
            din = 8'(8'h11 * (i + 1));
            step();
            if (i == 2) chk("t1_no_early_valid", 32'(q_valid), 32'(0));
        end
        din_valid = 1'b0;
        chk("t1_latency_valid", 32'(q_valid), 32'(1));
        chk("t1_first_q", 32'(q), 32'h11);
        chk("t1_peak_occ", 32'(occupancy), 32'(4));
        for (int i = 1; i < 4; i++) begin
            step();
            chk("t1_stream_valid", 32'(q_valid), 32'(1));
            chk("t1_stream_q", 32'(q), 32'(8'(8'h11 * (i + 1))));
        end
        step();
        chk("t1_drained", 32'(occupancy), 32'(0));

        // 2: back-pressure fills the pipe, then release
        q_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 8; c++) begin
            din_valid = 1'b1;
            din = 8'(8'hA0 + idx);
            step();
            if (s_in) idx++;
        end
        chk("t2_accepted", 32'(idx), 32'(4));
        chk("t2_din_ready_low", 32'(din_ready), 32'(0));
        chk("t2_occ_full", 32'(occupancy), 32'(4));
        chk("t2_q_held", 32'(q), 32'hA0);
        q_ready = 1'b1;
        got.delete();
        for (int c = 0; c < 20 && got.size() < 6; c++) begin
            din_valid = (idx < 6);
            din = 8'(8'hA0 + idx);
            step();
            if (s_in) idx++;
            if (s_out) got.push_back(s_q);
        end
        din_valid = 1'b0;
        chk("t2_delivered_count", 32'(got.size()), 32'(6));
        for (int i = 0; i < got.size(); i++) chk("t2_order", 32'(got[i]), 32'(8'(8'hA0 + i)));
        repeat (5) step();

        // 3: bubble collapse under a stalled sink
        q_ready = 1'b0;
        din_valid = 1'b1; din = 8'h01; step();
        din_valid = 1'b0; step(); step();
        din_valid = 1'b1; din = 8'h02; step();
        din_valid = 1'b0;
        repeat (4) step();
        chk("t3_occ", 32'(occupancy), 32'(2));
        chk("t3_head", 32'(q), 32'h01);
        q_ready = 1'b1;
        step();
        chk("t3_adjacent_valid", 32'(q_valid), 32'(1));
        chk("t3_adjacent_q", 32'(q), 32'h02);
        step();
        chk("t3_empty", 32'(occupancy), 32'(0));

        // 4: full pipe with simultaneous in/out
        q_ready = 1'b0;
        sent.delete(); got.delete();
        for (int i = 0; i < 4; i++) begin
            din_valid = 1'b1; din = 8'($urandom);
            step();
            if (s_in) sent.push_back(s_din);
        end
        chk("t4_full", 32'(occupancy), 32'(4));
        q_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            din_valid = 1'b1; din = 8'($urandom);
            step();
            if (s_in) sent.push_back(s_din);
            if (s_out) got.push_back(s_q);
            chk("t4_occ_steady", 32'(occupancy), 32'(4));
        end
        din_valid = 1'b0;
        chk("t4_out_count", 32'(got.size()), 32'(10));
        for (int i = 0; i < got.size() && i < sent.size(); i++)
            chk("t4_delay4", 32'(got[i]), 32'(sent[i]));
        repeat (5) step();

        // 5: flush with three beats in flight and a beat offered
        q_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            din_valid = 1'b1; din = 8'(8'hC0 + i); step();
        end
        chk("t5_occ3", 32'(occupancy), 32'(3));
        din_valid = 1'b1; din = 8'h77; flush = 1'b1;
        step();
        chk("t5_no_accept", 32'(s_in), 32'(0));
        flush = 1'b0; din_valid = 1'b0;
        chk("t5_occ0", 32'(occupancy), 32'(0));
        chk("t5_q_valid", 32'(q_valid), 32'(0));
        chk("t5_q_reset", 32'(q), 32'(0));

        // 6: asynchronous reset between edges
        for (int i = 0; i < 2; i++) begin
            din_valid = 1'b1; din = 8'(8'hE0 + i); step();
        end
        din_valid = 1'b0;
        chk("t6_occ2", 32'(occupancy), 32'(2));
        #2;
        rst = 1'b1;
        #1;
        chk("t6_rst_q_valid", 32'(q_valid), 32'(0));
        chk("t6_rst_occ", 32'(occupancy), 32'(0));
        chk("t6_rst_q", 32'(q), 32'(0));
        chk("t6_rst_din_ready", 32'(din_ready), 32'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        q_ready = 1'b1;
        din_valid = 1'b1; din = 8'h5A; step();
        din_valid = 1'b0; step(); step();
        chk("t6_not_early", 32'(q_valid), 32'(0));
        step();
        chk("t6_latency_valid", 32'(q_valid), 32'(1));
        chk("t6_latency_q", 32'(q), 32'h5A);
        step();

        // Random traffic against the scoreboard
        for (int c = 0; c < 400; c++) begin
            din_valid = 1'($urandom_range(0, 1));
            din       = 8'($urandom);
            q_ready   = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 29) == 0);
            step();
        end
        flush = 1'b0; din_valid = 1'b0; q_ready = 1'b1;
        repeat (6) step();
        chk("rand_drained", 32'(occupancy), 32'(0));

        // WIDTH=1, DEPTH=1: D flip-flop with enable
        exp_qb = 1'b0;
        for (int i = 0; i < 24; i++) begin
            din_valid_b = 1'($urandom_range(0, 1));
            din_b       = 1'($urandom);
            step();
            exp_vb = din_valid_b;
            if (din_valid_b) exp_qb = din_b;
            chk("b_q_valid", 32'(q_valid_b), 32'(exp_vb));
            chk("b_q", 32'(q_b), 32'(exp_qb));
            chk("b_occ", 32'(occ_b), 32'(exp_vb));
        end
        din_valid_b = 1'b1; din_b = 1'b1;
        step();
        q_ready_b = 1'b0; din_b = 1'b0;
        #1;
        chk("b_full_din_ready", 32'(din_ready_b), 32'(0));
        step();
        chk("b_hold_q", 32'(q_b), 32'(1));
        chk("b_hold_valid", 32'(q_valid_b), 32'(1));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
